// File: rtl/ins_fetcher_if.sv
// ins_fetcher_if: fetch-side bus bundle for ins_fetcher.
// Groups the instruction-memory request/response port, the decoder
// presentation/redirect port, the ROB flush port and the branch-history
// update port. The master modport is the fetcher; the slave modport is the
// surrounding memory/decoder/ROB environment.
//   mem_req_valid/mem_req_addr/mem_req_ready : fetch request handshake
//   mem_resp_valid/mem_resp_data             : one-cycle response pulse
//   ins_ready/ins/pc/pred_jump               : instruction presented to decoder
//   dec_stall/dec_clear/dec_new_addr         : decoder backpressure and redirect
//   rob_clear/rob_new_pc                     : mispredict flush
//   bht_upd_valid/bht_upd_pc/bht_upd_taken   : resolved branch outcome
interface ins_fetcher_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pred_jump;
    logic        dec_stall;
    logic        dec_clear;
    logic [31:0] dec_new_addr;
    logic        rob_clear;
    logic [31:0] rob_new_pc;
    logic        bht_upd_valid;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;

    modport master (
        output mem_req_valid, mem_req_addr, ins_ready, ins, pc, pred_jump,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        input  dec_stall, dec_clear, dec_new_addr, rob_clear, rob_new_pc,
        input  bht_upd_valid, bht_upd_pc, bht_upd_taken
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, ins_ready, ins, pc, pred_jump,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        output dec_stall, dec_clear, dec_new_addr, rob_clear, rob_new_pc,
        output bht_upd_valid, bht_upd_pc, bht_upd_taken
    );
endinterface

// File: rtl/ins_fetcher.sv
// ins_fetcher: front-end instruction fetcher with next-PC branch prediction.
// Ports:
//   clk_in : system clock
//   rst_in : asynchronous active-low reset
//   rdy_in : global ready, all state frozen while low
//   bus    : ins_fetcher_if.master (memory, decoder, ROB and BHT-update signals)
// Optional feature macro FETCH_BHT_EN: when defined, conditional branches are
// predicted by a table of 2-bit saturating counters; otherwise backward
// branches (negative offset) are predicted taken.
module ins_fetcher #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    ins_fetcher_if.master bus
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state;
    logic        discard;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        ins_ready_r;
    logic [31:0] ins_r;
    logic [31:0] pc_r;
    logic        pred_r;

    logic        redirect;
    logic [31:0] target;
    logic        handshake;
    logic        is_branch;
    logic [31:0] br_imm;
    logic        predict_taken;
    logic        pred;
    logic [31:0] resp_next_pc;
    logic        unused_bht;

    assign redirect     = bus.rob_clear | bus.dec_clear;
    assign target       = bus.rob_clear ? bus.rob_new_pc : bus.dec_new_addr;
    // Memory only sees a request once our registered valid is up.
    assign handshake    = (state == S_REQ) && req_valid && bus.mem_req_ready;
    assign is_branch    = bus.mem_resp_data[6:0] == 7'b1100011;
    assign br_imm       = {{19{bus.mem_resp_data[31]}}, bus.mem_resp_data[31], bus.mem_resp_data[7],
                           bus.mem_resp_data[30:25], bus.mem_resp_data[11:8], 1'b0};
    assign pred         = is_branch & predict_taken;
    assign resp_next_pc = pred ? fetch_pc + br_imm : fetch_pc + 32'd4;

`ifdef FETCH_BHT_EN
    logic [1:0]           bht [2**BHT_IDX_W];
    logic [BHT_IDX_W-1:0] rd_idx;
    logic [BHT_IDX_W-1:0] up_idx;

    assign rd_idx        = fetch_pc[BHT_IDX_W+1:2];
    assign up_idx        = bus.bht_upd_pc[BHT_IDX_W+1:2];
    // Read is of the registered table, so a same-cycle update is not visible.
    assign predict_taken = bht[rd_idx][1];
    assign unused_bht    = ^{bus.bht_upd_pc[31:BHT_IDX_W+2], bus.bht_upd_pc[1:0]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
        end else if (rdy_in && bus.bht_upd_valid) begin
            bht[up_idx] <= bus.bht_upd_taken ? ((bht[up_idx] == 2'b11) ? 2'b11 : bht[up_idx] + 2'b01)
                                             : ((bht[up_idx] == 2'b00) ? 2'b00 : bht[up_idx] - 2'b01);
        end
    end
`else
    localparam int unused_bht_idx_w = BHT_IDX_W;
    // Static backward-taken: a set sign bit means a negative branch offset.
    assign predict_taken = bus.mem_resp_data[31];
    assign unused_bht    = ^{bus.bht_upd_valid, bus.bht_upd_pc, bus.bht_upd_taken};
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= S_REQ;
            discard     <= 1'b0;
            fetch_pc    <= RESET_PC;
            next_pc     <= 32'd0;
            req_valid   <= 1'b0;
            req_addr    <= 32'd0;
            ins_ready_r <= 1'b0;
            ins_r       <= 32'd0;
            pc_r        <= 32'd0;
            pred_r      <= 1'b0;
        end else if (rdy_in) begin
            if (state == S_REQ) begin
                if (redirect) fetch_pc <= target;
                if (handshake) begin
                    // A redirect racing the accept must throw away that response.
                    state     <= S_WAIT;
                    req_valid <= 1'b0;
                    discard   <= redirect;
                end else begin
                    req_valid <= 1'b1;
                    req_addr  <= redirect ? target : fetch_pc;
                end
            end else if (state == S_WAIT) begin
                if (redirect) fetch_pc <= target;
                if (bus.mem_resp_valid) begin
                    if (redirect || discard) begin
                        state     <= S_REQ;
                        discard   <= 1'b0;
                        req_valid <= 1'b1;
                        req_addr  <= redirect ? target : fetch_pc;
                    end else begin
                        state       <= S_HOLD;
                        ins_ready_r <= 1'b1;
                        ins_r       <= bus.mem_resp_data;
                        pc_r        <= fetch_pc;
                        pred_r      <= pred;
                        next_pc     <= resp_next_pc;
                    end
                end else if (redirect) begin
                    discard <= 1'b1;
                end
            end else begin
                if (redirect || !bus.dec_stall) begin
                    state       <= S_REQ;
                    ins_ready_r <= 1'b0;
                    req_valid   <= 1'b1;
                    fetch_pc    <= redirect ? target : next_pc;
                    req_addr    <= redirect ? target : next_pc;
                end
            end
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = req_addr;
    assign bus.ins_ready     = ins_ready_r;
    assign bus.ins           = ins_r;
    assign bus.pc            = pc_r;
    assign bus.pred_jump     = pred_r;
endmodule

// File: tb/tb_ins_fetcher.sv
// tb_ins_fetcher: directed self-checking bench for ins_fetcher.
module tb_ins_fetcher;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   checks = 0;
    int   failures = 0;

    ins_fetcher_if bus ();

    ins_fetcher #(.RESET_PC(32'h0), .BHT_IDX_W(6)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept a request at the expected address, answer two cycles later.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data);
        chk("serve_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("serve_req_addr", bus.mem_req_addr, addr);
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        chk("serve_valid_drop", {31'd0, bus.mem_req_valid}, 32'd0);
        tick;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("serve_ins_ready", {31'd0, bus.ins_ready}, 32'd1);
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'd0;
        bus.dec_stall      = 1'b0;
        bus.dec_clear      = 1'b0;
        bus.dec_new_addr   = 32'd0;
        bus.rob_clear      = 1'b0;
        bus.rob_new_pc     = 32'd0;
        bus.bht_upd_valid  = 1'b0;
        bus.bht_upd_pc     = 32'd0;
        bus.bht_upd_taken  = 1'b0;
        #2;
        chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("rst_req_addr", bus.mem_req_addr, 32'd0);
        chk("rst_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("rst_ins", bus.ins, 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_pred", {31'd0, bus.pred_jump}, 32'd0);
        tick;
        tick;
        rst_in = 1'b1;
        tick;
        // first fetch, consumed immediately
        serve(32'h0, 32'h0000_0013);
        chk("t1_ins", bus.ins, 32'h13);
        chk("t1_pc", bus.pc, 32'h0);
        tick;
        chk("t1_ready_drop", {31'd0, bus.ins_ready}, 32'd0);
        chk("t1_next_addr", bus.mem_req_addr, 32'h4);
        chk("t1_next_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        // decoder stall holds the instruction
        bus.dec_stall = 1'b1;
        serve(32'h4, 32'h0010_0093);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t2_hold_ready", {31'd0, bus.ins_ready}, 32'd1);
            chk("t2_hold_pc", bus.pc, 32'h4);
            chk("t2_hold_ins", bus.ins, 32'h0010_0093);
            chk("t2_hold_req", {31'd0, bus.mem_req_valid}, 32'd0);
        end
        bus.dec_stall = 1'b0;
        tick;
        chk("t2_ready_drop", {31'd0, bus.ins_ready}, 32'd0);
        chk("t2_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("t2_req_addr", bus.mem_req_addr, 32'h8);
        // redirect while waiting, response arrives later
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        bus.dec_clear = 1'b1;
        bus.dec_new_addr = 32'h200;
        tick;
        bus.dec_clear = 1'b0;
        chk("t4a_wait_req", {31'd0, bus.mem_req_valid}, 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h0050_0093;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("t4a_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("t4a_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("t4a_req_addr", bus.mem_req_addr, 32'h200);
        // redirect in the same cycle as the response
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        tick;
        bus.mem_resp_valid = 1'b1;
        bus.dec_clear = 1'b1;
        bus.dec_new_addr = 32'h240;
        tick;
        bus.mem_resp_valid = 1'b0;
        bus.dec_clear = 1'b0;
        chk("t4b_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("t4b_req_addr", bus.mem_req_addr, 32'h240);
        tick;
        chk("t4b_ins_ready2", {31'd0, bus.ins_ready}, 32'd0);
        // redirect in the same cycle as the request handshake
        bus.mem_req_ready = 1'b1;
        bus.dec_clear = 1'b1;
        bus.dec_new_addr = 32'h400;
        tick;
        bus.mem_req_ready = 1'b0;
        bus.dec_clear = 1'b0;
        chk("hs_clr_req", {31'd0, bus.mem_req_valid}, 32'd0);
        bus.mem_resp_valid = 1'b1;
        tick;
        bus.mem_resp_valid = 1'b0;
        chk("hs_clr_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("hs_clr_req_addr", bus.mem_req_addr, 32'h400);
        // rdy_in low freezes everything
        rdy_in = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.dec_clear = 1'b1;
        bus.dec_new_addr = 32'h500;
        tick;
        tick;
        tick;
        chk("rdy_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("rdy_req_addr", bus.mem_req_addr, 32'h400);
        rdy_in = 1'b1;
        bus.mem_req_ready = 1'b0;
        bus.dec_clear = 1'b0;
        // branch prediction
        bus.rob_clear = 1'b1;
        bus.rob_new_pc = 32'h100;
        tick;
        bus.rob_clear = 1'b0;
        serve(32'h100, 32'hFE00_0CE3);
        chk("t3_back_pred", {31'd0, bus.pred_jump}, 32'd1);
        chk("t3_back_pc", bus.pc, 32'h100);
        tick;
        chk("t3_back_next", bus.mem_req_addr, 32'hF8);
        bus.rob_clear = 1'b1;
        tick;
        bus.rob_clear = 1'b0;
        serve(32'h100, 32'h0000_0863);
        chk("t3_fwd_pred", {31'd0, bus.pred_jump}, 32'd0);
        tick;
        chk("t3_fwd_next", bus.mem_req_addr, 32'h104);
        // rob_clear wins over dec_clear in S_HOLD
        bus.dec_stall = 1'b1;
        serve(32'h104, 32'h0000_0013);
        tick;
        chk("t5_stalled", {31'd0, bus.ins_ready}, 32'd1);
        bus.rob_clear = 1'b1;
        bus.rob_new_pc = 32'h300;
        bus.dec_clear = 1'b1;
        bus.dec_new_addr = 32'h200;
        tick;
        bus.rob_clear = 1'b0;
        bus.dec_clear = 1'b0;
        bus.dec_stall = 1'b0;
        chk("t5_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("t5_req_addr", bus.mem_req_addr, 32'h300);
        // 32-bit wrap-around of pc+4
        bus.rob_clear = 1'b1;
        bus.rob_new_pc = 32'hFFFF_FFFC;
        tick;
        bus.rob_clear = 1'b0;
        serve(32'hFFFF_FFFC, 32'h0000_0013);
        tick;
        chk("wrap_next", bus.mem_req_addr, 32'h0);
        // asynchronous reset in S_HOLD
        bus.rob_clear = 1'b1;
        bus.rob_new_pc = 32'h100;
        tick;
        bus.rob_clear = 1'b0;
        bus.dec_stall = 1'b1;
        serve(32'h100, 32'hFE00_0CE3);
        chk("t6_pre_pred", {31'd0, bus.pred_jump}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("t6_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("t6_ins", bus.ins, 32'd0);
        chk("t6_pc", bus.pc, 32'd0);
        chk("t6_pred", {31'd0, bus.pred_jump}, 32'd0);
        chk("t6_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("t6_req_addr", bus.mem_req_addr, 32'd0);
        tick;
        rst_in = 1'b1;
        bus.dec_stall = 1'b0;
        tick;
        chk("t6_rel_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("t6_rel_addr", bus.mem_req_addr, 32'h0);
        // branch-history updates (ignored without the table)
        bus.bht_upd_valid = 1'b1;
        bus.bht_upd_pc = 32'h100;
        bus.bht_upd_taken = 1'b1;
        tick;
        tick;
        bus.bht_upd_valid = 1'b0;
        bus.rob_clear = 1'b1;
        bus.rob_new_pc = 32'h100;
        tick;
        bus.rob_clear = 1'b0;
        serve(32'h100, 32'h0000_0863);
`ifdef FETCH_BHT_EN
        chk("bht_pred", {31'd0, bus.pred_jump}, 32'd1);
        tick;
        chk("bht_next", bus.mem_req_addr, 32'h110);
`else
        chk("bht_pred", {31'd0, bus.pred_jump}, 32'd0);
        tick;
        chk("bht_next", bus.mem_req_addr, 32'h104);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ins_fetcher.md
Name: ins_fetcher

Overview:
Front-end instruction fetcher. It is the producing side of the fetch/decode handshake: it requests instruction words from the instruction memory port and presents one instruction at a time to the decoder (ins_ready/ins/pc/pred_jump). It honours decoder stall and redirect requests, and ROB mispredict flushes. Conditional branches get a next-PC prediction so fetch can continue speculatively.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset.
BHT_IDX_W, 6, log2 of the number of branch-history-table entries (used only with FETCH_BHT_EN).

Ports:
clk_in  input  1  system clock.
rst_in  input  1  asynchronous, active-low reset.
rdy_in  input  1  global ready; when low all state freezes.
mem_req_valid  output  1  fetch request valid.
mem_req_addr  output  32  fetch word address.
mem_req_ready  input  1  memory accepts the request this cycle.
mem_resp_valid  input  1  one-cycle pulse; instruction word returned.
mem_resp_data  input  32  returned instruction word.
ins_ready  output  1  ins/pc/pred_jump are valid for the decoder.
ins  output  32  instruction word.
pc  output  32  address of ins.
pred_jump  output  1  predicted taken (meaningful for B-type only).
dec_stall  input  1  decoder cannot accept the presented instruction.
dec_clear  input  1  one-cycle decoder redirect pulse (JAL/JALR/branch).
dec_new_addr  input  32  redirect target from the decoder.
rob_clear  input  1  one-cycle ROB mispredict flush.
rob_new_pc  input  32  correct PC from the ROB.
bht_upd_valid  input  1  branch resolved (ROB commit).
bht_upd_pc  input  32  PC of the resolved branch.
bht_upd_taken  input  1  actual outcome.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - fetch_pc=RESET_PC; state=S_REQ; discard=0.
  - All outputs are 0.
- rdy_in=0: no state or output changes; mem_req_valid and mem_req_addr are held.
- S_REQ:
  - mem_req_valid=1, mem_req_addr=fetch_pc.
  - On mem_req_valid&&mem_req_ready, go to S_WAIT; mem_req_valid drops the next cycle.
  - mem_req_addr may change before acceptance; memory samples the address only at accept.
- S_WAIT: wait for mem_resp_valid.
  - If discard=1: clear discard, go to S_REQ; the response is dropped.
  - Otherwise, next cycle: ins=mem_resp_data, pc=fetch_pc, pred_jump=prediction, ins_ready=1, next_pc computed; go to S_HOLD.
- S_HOLD:
  - ins, pc and pred_jump are held stable and ins_ready=1.
  - Handoff: in a cycle with dec_stall=0, the instruction counts as consumed. Next cycle: ins_ready=0, fetch_pc=next_pc, go to S_REQ.
  - Each instruction is presented exactly once; the decoder detects a new instruction by a pc change.
- Next PC:
  - If opcode==7'b1100011 and predicted taken: pc + sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - Otherwise pc+4.
  - 32-bit wrap-around, no overflow detection.
  - JAL and JALR use pc+4 and rely on dec_clear.
- Redirect:
  - rob_clear has priority over dec_clear; both have priority over the S_HOLD handoff and dec_stall.
  - Effect, next cycle: fetch_pc=target and ins_ready=0. The next state depends on the current state:
    - S_HOLD: go to S_REQ.
    - S_REQ with no handshake: stay in S_REQ; mem_req_addr updates to the target.
    - S_REQ with the handshake in the same cycle: discard=1, go to S_WAIT.
    - S_WAIT with no response: discard=1, stay in S_WAIT.
    - S_WAIT with a response in the same cycle: drop the response, go to S_REQ.
  - A second redirect while discard=1 only updates fetch_pc.
- Latency:
  - Response to ins_ready: 1 cycle.
  - Consume to next mem_req_valid: 1 cycle.
- At most one outstanding memory request.

Optional Feature:
Macro FETCH_BHT_EN.
- Defined:
  - Table of 2^BHT_IDX_W 2-bit saturating counters, indexed by pc[BHT_IDX_W+1:2]. All entries reset to 2'b01.
  - Prediction: taken iff counter[1].
  - On bht_upd_valid, the indexed counter increments if bht_upd_taken=1 and decrements if 0, saturating at 3 and 0.
  - A same-cycle read and update of one entry returns the old value.
- Undefined:
  - Static backward-taken: predicted taken iff ins[31]=1.
  - bht_* inputs are ignored and no table is built.

Test Plan:
1. Reset release, RESET_PC=0, memory ready, responds 0x00000013 two cycles after accept -> mem_req_addr=0; ins_ready=1, ins=0x13, pc=0; with dec_stall=0 the next request is at addr 4.
2. Instruction presented, dec_stall=1 for 5 cycles -> ins/pc/ins_ready stable, mem_req_valid=0; stall drops -> request at pc+4 the next cycle.
3. pc=0x100, ins=0xFE000CE3 (beq -8) -> pred_jump=1, next request 0xF8. ins=0x00000863 (beq +16) -> pred_jump=0, next request 0x104.
4. Request for 0x8 in S_WAIT, dec_clear with dec_new_addr=0x200 -> response for 0x8 dropped, ins_ready stays 0, next request 0x200. Repeat with the response in the same cycle as the clear -> same result.
5. rob_clear with 0x300 and dec_clear with 0x200 in the same cycle, in S_HOLD -> ins_ready=0, next request 0x300.
6. rst_in low mid-S_HOLD -> outputs 0 without a clock edge; on release, request at RESET_PC. With FETCH_BHT_EN: two taken updates for pc 0x100 -> forward beq at 0x100 predicted taken.
